// File: rtl/trivium_pkg.sv
// trivium_pkg: shared widths, defaults, FSM states and key/IV byte placement for the Trivium keystream block
package trivium_pkg;
  localparam int STATE_W = 288;
  localparam int KEY_W = 80;
  localparam int IV_W = 80;
  localparam int CFG_BYTES = 20;
  localparam int DEF_INIT_ROUNDS = 1152;
  localparam int KEY_BYTES = KEY_W / 8;
  localparam int IV_BASE = 93;
  typedef enum logic [1:0] {IDLE, LOAD, INIT, RUN} state_e;
  // key bytes land at s1.., IV bytes at s94..; returns the 0-based LSB position of byte n
  function automatic logic [8:0] byte_base(input logic [4:0] n);
    return n < 5'(KEY_BYTES) ? 9'(n) * 9'd8 : 9'(n - 5'(KEY_BYTES)) * 9'd8 + 9'(IV_BASE);
  endfunction
endpackage

// File: rtl/trivium_stream_if.sv
// trivium_stream_if: key/IV configuration and keystream handshake bundle
interface trivium_stream_if #(parameter int W = 8);
  logic cfg_start;
  logic cfg_valid;
  logic [7:0] cfg_data;
  logic cfg_ready;
  logic ks_valid;
  logic ks_ready;
  logic [W-1:0] ks_data;
  logic busy;
  logic [31:0] ks_count;
  modport master (
    output cfg_start, cfg_valid, cfg_data, ks_ready,
    input cfg_ready, ks_valid, ks_data, busy, ks_count
  );
  modport slave (
    input cfg_start, cfg_valid, cfg_data, ks_ready,
    output cfg_ready, ks_valid, ks_data, busy, ks_count
  );
endinterface

// File: rtl/trivium_round.sv
// trivium_round: one combinational single-bit Trivium state update with its keystream bit
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] s,
  output logic [STATE_W-1:0] s_next,
  output logic               z
);
  logic t1, t2, t3;
  // bit s[j] holds Trivium s(j+1)
  always_comb begin
    t1 = s[65] ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z = t1 ^ t2 ^ t3;
    s_next = {s[286:177], t2 ^ (s[174] & s[175]) ^ s[263],
              s[175:93],  t1 ^ (s[90] & s[91]) ^ s[170],
              s[91:0],    t3 ^ (s[285] & s[286]) ^ s[68]};
  end
endmodule

// File: rtl/trivium_stream.sv
// trivium_stream: Trivium keystream generator with byte-wise key/IV load and W-bit output words
module trivium_stream
  import trivium_pkg::*;
#(
  parameter int W = 8,
  parameter int INIT_ROUNDS = DEF_INIT_ROUNDS
) (
  input logic clk,
  input logic rst_n,
  trivium_stream_if.slave bus
);
  localparam int INIT_CYC = INIT_ROUNDS / W;
  state_e state_q, state_d;
  logic [STATE_W-1:0] st;
  logic [STATE_W-1:0] chain [W+1];
  logic [W-1:0] z;
  logic [4:0] byte_cnt;
  logic [15:0] rnd_cnt;
  logic ks_valid_q;
  logic [W-1:0] ks_data_q;
  logic [31:0] ks_count_q;
  logic last_byte, last_rnd, advance;
  assign chain[0] = st;
  for (genvar i = 0; i < W; i++) begin : g_round
    trivium_round u_round (.s(chain[i]), .s_next(chain[i+1]), .z(z[i]));
  end
  always_comb begin
    last_byte = state_q == LOAD && bus.cfg_valid && byte_cnt == 5'(CFG_BYTES - 1);
    last_rnd = state_q == INIT && rnd_cnt == 16'(INIT_CYC - 1);
    advance = state_q == RUN && (!ks_valid_q || bus.ks_ready);
    state_d = bus.cfg_start ? LOAD : last_byte ? INIT : last_rnd ? RUN : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // cfg_start pre-clears the state with the constant ones so LOAD only writes key/IV bytes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= '0;
      byte_cnt <= '0;
      rnd_cnt <= '0;
      ks_valid_q <= 1'b0;
      ks_data_q <= '0;
      ks_count_q <= '0;
    end else if (bus.cfg_start) begin
      st <= {3'b111, {(STATE_W - 3){1'b0}}};
      byte_cnt <= '0;
      rnd_cnt <= '0;
      ks_valid_q <= 1'b0;
      ks_count_q <= '0;
    end else begin
      if (state_q == LOAD && bus.cfg_valid) begin
        st[byte_base(byte_cnt) +: 8] <= bus.cfg_data;
        byte_cnt <= byte_cnt + 5'd1;
      end
      if (state_q == INIT) begin
        st <= chain[W];
        rnd_cnt <= last_rnd ? '0 : rnd_cnt + 16'd1;
      end
      if (advance) begin
        st <= chain[W];
        ks_data_q <= z;
        ks_valid_q <= 1'b1;
      end
      if (ks_valid_q && bus.ks_ready && ks_count_q != '1) ks_count_q <= ks_count_q + 32'd1;
    end
  end
  assign bus.cfg_ready = state_q == LOAD;
  assign bus.busy = state_q == LOAD || state_q == INIT;
  assign bus.ks_valid = ks_valid_q;
  assign bus.ks_data = ks_data_q;
  assign bus.ks_count = ks_count_q;
endmodule

// File: tb/tb_trivium_stream.sv
// tb_trivium_stream: directed checks of trivium_stream at W=8 with W=1/W=64 instances cross-checked on the same key
module tb_trivium_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  trivium_stream_if #(.W(8)) b8();
  trivium_stream_if #(.W(1)) b1();
  trivium_stream_if #(.W(64)) b64();
  trivium_stream #(.W(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  trivium_stream #(.W(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  trivium_stream #(.W(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));
  assign b1.cfg_start = b8.cfg_start;
  assign b1.cfg_valid = b8.cfg_valid;
  assign b1.cfg_data = b8.cfg_data;
  assign b1.ks_ready = 1'b1;
  assign b64.cfg_start = b8.cfg_start;
  assign b64.cfg_valid = b8.cfg_valid;
  assign b64.cfg_data = b8.cfg_data;
  assign b64.ks_ready = 1'b1;

  typedef struct {
    logic start;
    logic valid;
    logic [7:0] data;
    logic ready;
    logic [2:0] exp;
  } vec_t;
  vec_t tbl[12];
  int nvec = 0, nerr = 0, n1 = 0, n64 = 0, ic1 = 0, ic64 = 0;
  bit mon_en = 1'b0;
  logic [2047:0] gold;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // bit-serial reference written directly from the s1..s288 description
  task automatic make_gold(input logic [79:0] key, input logic [79:0] iv);
    bit s[1:288];
    bit t1, t2, t3, z;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i] = key[i-1];
      s[93+i] = iv[i-1];
    end
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    for (int r = 0; r < 1152 + 2048; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 93; i > 1; i--) s[i] = s[i-1];
      s[1] = t3;
      for (int i = 177; i > 94; i--) s[i] = s[i-1];
      s[94] = t1;
      for (int i = 288; i > 178; i--) s[i] = s[i-1];
      s[178] = t2;
      if (r >= 1152) gold[r-1152] = z;
    end
  endtask

  task automatic feed(input logic [79:0] key, input logic [79:0] iv);
    for (int k = 0; k < 20; k++) begin
      chk("load_ready", 64'(b8.cfg_ready), 64'(1));
      b8.cfg_valid = 1'b1;
      b8.cfg_data = k < 10 ? key[8*k +: 8] : iv[8*(k-10) +: 8];
      step();
    end
    b8.cfg_valid = 1'b0;
    chk("load_done", 64'({b8.cfg_ready, b8.busy}), 64'(2'b01));
  endtask

  task automatic wait_run(output int ic);
    ic = 0;
    while (b8.busy && ic < 3000) begin
      ic++;
      step();
    end
  endtask

  task automatic words(input int n);
    chk("first_run_idle", 64'(b8.ks_valid), 64'(0));
    for (int j = 0; j < n; j++) begin
      step();
      chk("w8_word", 64'({b8.ks_valid, b8.ks_data}), 64'({1'b1, gold[8*j +: 8]}));
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    if (b1.busy && !b1.cfg_ready) ic1++;
    if (b64.busy && !b64.cfg_ready) ic64++;
    if (b1.ks_valid && n1 < 512) begin
      chk("w1_bit", 64'(b1.ks_data), 64'(gold[n1]));
      n1++;
    end
    if (b64.ks_valid && n64 < 16) begin
      chk("w64_word", b64.ks_data, gold[64*n64 +: 64]);
      n64++;
    end
  end

  initial begin
    int ic, t, e, hs;
    logic r;
    b8.cfg_start = 1'b0;
    b8.cfg_valid = 1'b0;
    b8.cfg_data = 8'h00;
    b8.ks_ready = 1'b0;
    tbl[0] = '{1'b0, 1'b1, 8'hAA, 1'b1, 3'b000};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'b000};
    tbl[2] = '{1'b1, 1'b1, 8'h55, 1'b0, 3'b110};
    for (int k = 0; k < 7; k++) tbl[3+k] = '{1'b0, 1'b1, 8'(17 * (k + 1)), 1'b0, 3'b110};
    tbl[10] = '{1'b1, 1'b1, 8'hFF, 1'b0, 3'b110};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'b110};
    make_gold(80'h80, 80'h0);
    repeat (2) step();
    chk("reset_state", 64'({b8.cfg_ready, b8.busy, b8.ks_valid, b8.ks_count, b8.ks_data}), 64'(0));
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      b8.cfg_start = tbl[i].start;
      b8.cfg_valid = tbl[i].valid;
      b8.cfg_data = tbl[i].data;
      b8.ks_ready = tbl[i].ready;
      step();
      chk("ctrl_table", 64'({b8.cfg_ready, b8.busy, b8.ks_valid}), 64'(tbl[i].exp));
    end
    b8.cfg_start = 1'b0;
    b8.cfg_valid = 1'b0;
    b8.ks_ready = 1'b1;
    mon_en = 1'b1;
    feed(80'h80, 80'h0);
    wait_run(ic);
    chk("init_len_w8", 64'(ic), 64'(144));
    words(64);
    step();
    b8.ks_ready = 1'b0;
    chk("count_64", 64'(b8.ks_count), 64'(64));
    t = 0;
    while ((n1 < 512 || n64 < 16) && t < 3000) begin
      t++;
      step();
    end
    chk("wide_narrow_done", 64'({n1 == 512, n64 == 16}), 64'(2'b11));
    chk("init_len_w1", 64'(ic1), 64'(1152));
    chk("init_len_w64", 64'(ic64), 64'(18));
    mon_en = 1'b0;
    chk("stall_hold", 64'({b8.ks_valid, b8.ks_data, b8.ks_count}), 64'({1'b1, gold[512 +: 8], 32'd64}));
    e = 64;
    hs = 0;
    for (int c = 0; c < 180; c++) begin
      chk("bp_word", 64'({b8.ks_valid, b8.ks_data}), 64'({1'b1, gold[8*e +: 8]}));
      r = 1'($urandom_range(0, 1));
      b8.ks_ready = r;
      step();
      if (r) begin
        e++;
        hs++;
      end
    end
    b8.ks_ready = 1'b0;
    chk("bp_count", 64'(b8.ks_count), 64'(64 + hs));
    b8.ks_ready = 1'b1;
    b8.cfg_start = 1'b1;
    step();
    b8.cfg_start = 1'b0;
    chk("restart_run", 64'({b8.ks_valid, b8.busy, b8.cfg_ready, b8.ks_count}), 64'({3'b011, 32'd0}));
    make_gold(80'h0123456789ABCDEF0011, 80'hFEDCBA98765432100F1E);
    feed(80'h0123456789ABCDEF0011, 80'hFEDCBA98765432100F1E);
    wait_run(ic);
    chk("init_len_reload", 64'(ic), 64'(144));
    words(16);
    rst_n = 1'b0;
    b8.cfg_start = 1'b1;
    step();
    chk("reset_in_run", 64'({b8.ks_valid, b8.busy, b8.cfg_ready, b8.ks_count, b8.ks_data}), 64'(0));
    b8.cfg_start = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 64'({b8.cfg_ready, b8.busy, b8.ks_valid}), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/trivium_stream.md
TRIVIUM_STREAM -- requirements
Module: trivium_stream

Interface
REQ-001 SHALL have parameter W, default 8: keystream bits produced per cycle; legal values 1, 2, 4, 8, 16, 32, 64 (each divides 1152).
REQ-002 SHALL have parameter INIT_ROUNDS, default 1152: warm-up single-bit updates; must be a multiple of W.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cfg_start  input  1  single-cycle pulse that begins a new key/IV load.
REQ-006 SHALL have port cfg_valid  input  1  cfg_data holds a valid key/IV byte.
REQ-007 SHALL have port cfg_data  input  8  key/IV byte.
REQ-008 SHALL have port cfg_ready  output  1  block accepts a byte this cycle.
REQ-009 SHALL have port ks_valid  output  1  ks_data holds a keystream word.
REQ-010 SHALL have port ks_ready  input  1  consumer takes ks_data this cycle.
REQ-011 SHALL have port ks_data  output  W  keystream word; bit 0 is the earliest-generated bit.
REQ-012 SHALL have port busy  output  1  high in LOAD or INIT.
REQ-013 SHALL have port ks_count  output  32  number of words accepted since entering RUN; saturates at 0xFFFFFFFF.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, INIT and RUN.
REQ-015 cfg_start SHALL move the FSM to LOAD from any state, clear the byte counter, ks_valid and ks_count, and discard any cfg_valid byte presented in the same cycle.
REQ-016 cfg_ready SHALL be high only in LOAD; a byte is accepted when cfg_valid and cfg_ready are both high.
REQ-017 Byte k (0..9) SHALL set key bits K(8k+i+1) = cfg_data[i]; byte 10+k (0..9) SHALL set IV bits IV(8k+i+1) = cfg_data[i].
REQ-018 On acceptance of byte 19, the block SHALL load state s1..s80=K, s81..s93=0, s94..s173=IV, s174..s285=0, s286..s288=1, then enter INIT on the next cycle.
REQ-019 In INIT the block SHALL apply W single-bit Trivium updates per cycle, with no output, for INIT_ROUNDS/W cycles, then enter RUN.
REQ-020 Each single-bit update SHALL compute:
- t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3;
- t1^=s91&s92^s171, t2^=s175&s176^s264, t3^=s286&s287^s69;
- shift s1..s93 <= (t3, s1..s92), s94..s177 <= (t1, s94..s176), s178..s288 <= (t2, s178..s287).
REQ-021 In RUN, when !ks_valid or ks_ready, the block SHALL apply W updates, register the W z bits into ks_data (first z at bit 0), and set ks_valid; otherwise state and ks_data SHALL hold.
REQ-022 The first ks_valid SHALL assert exactly one cycle after entering RUN; with ks_ready held high, one new word SHALL be delivered per cycle.
REQ-023 ks_data SHALL remain stable while ks_valid and !ks_ready.
REQ-024 ks_count SHALL increment on each ks_valid&ks_ready handshake and hold at 0xFFFFFFFF.
REQ-025 In IDLE, cfg_valid and ks_ready SHALL be ignored; cfg_ready and ks_valid SHALL be 0.

Reset
REQ-026 On rst_n low at a clock edge, the block SHALL force: FSM=IDLE, 288-bit state=0, byte counter=0, round counter=0, ks_valid=0, ks_data=0, ks_count=0, cfg_ready=0, busy=0.
REQ-027 Reset SHALL take priority over cfg_start and abort any LOAD, INIT or RUN with no partial output.

Structure
REQ-028 The shared package trivium_pkg SHALL hold STATE_W=288, KEY_W=80, IV_W=80, CFG_BYTES=20, the default INIT_ROUNDS=1152, and the FSM state enum.
REQ-029 One sub-module, trivium_round (combinational single-bit update: state in -> state out, z), SHALL be chained W times by generate.

Verification
REQ-030 Reset during RUN with ks_ready=1 -> the next cycle shows ks_valid=0, busy=0, ks_count=0 and cfg_ready=0.
REQ-031 Load key=0x00 bytes except byte0=0x80, IV all 0x00, W=8 -> busy for 20+144 cycles; the first 64 ks_data bytes match a bit-serial golden model.
REQ-032 Same key/IV with W=1 and W=64 -> the concatenated keystream is bit-identical to the W=8 run; the INIT phase lasts 1152 and 18 cycles respectively.
REQ-033 Random ks_ready backpressure (50%) -> ks_data stays stable while stalled; no word is lost or duplicated against the model; ks_count equals the number of handshakes.
REQ-034 cfg_start asserted together with cfg_valid after 7 bytes -> that byte is dropped, the counter restarts, and 20 fresh bytes are required before INIT.
REQ-035 cfg_start mid-RUN -> ks_valid drops the next cycle; after reload, the stream matches the model for the new key from bit 0.
